// File: rtl/maquina_mesi.sv
// MESI coherence controller for one processor cache: CPU-side and snooped-bus-side
// transition logic, each producing registered next-state and bus-action outputs.
module maquina_mesi (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] estadoAnteriorCpu,
  input  logic       writeHit,
  input  logic       readHit,
  input  logic       writeMiss,
  input  logic       readMiss,
  input  logic       sharedIn,
  output logic [2:0] proximoEstadoCpu,
  output logic       sendReadMiss,
  output logic       sendWriteMiss,
  output logic       sendInvalidate,
  output logic       sendWriteBack,
  input  logic [2:0] estadoAnteriorBus,
  input  logic       busReadMiss,
  input  logic       busWriteMiss,
  input  logic       busInvalidate,
  output logic       sendAbortMemoryAccess,
  output logic [2:0] proximoEstadoBus
);

  typedef enum logic [2:0] {
    ST_I = 3'b000,
    ST_M = 3'b001,
    ST_S = 3'b010,
    ST_E = 3'b011
  } mesi_t;

  // Any encoding outside the four legal states behaves as an invalid line.
  function automatic mesi_t decode(input logic [2:0] raw);
    case (raw)
      3'b001:  decode = ST_M;
      3'b010:  decode = ST_S;
      3'b011:  decode = ST_E;
      default: decode = ST_I;
    endcase
  endfunction

  mesi_t cpu_cur, cpu_nxt, cpu_q;
  mesi_t bus_cur, bus_nxt, bus_q;
  mesi_t fill_state;
  logic  read_miss_nxt, write_miss_nxt, invalidate_nxt, write_back_nxt;
  logic  abort_nxt;
  logic  read_miss_q, write_miss_q, invalidate_q, write_back_q, abort_q;

  assign cpu_cur    = decode(estadoAnteriorCpu);
  assign bus_cur    = decode(estadoAnteriorBus);
  assign fill_state = sharedIn ? ST_S : ST_E;

  // CPU side: writeMiss > writeHit > readMiss > readHit
  always_comb begin
    cpu_nxt        = cpu_cur;
    read_miss_nxt  = 1'b0;
    write_miss_nxt = 1'b0;
    invalidate_nxt = 1'b0;
    write_back_nxt = 1'b0;
    if (writeMiss) begin
      write_miss_nxt = 1'b1;
      write_back_nxt = (cpu_cur == ST_M);
      cpu_nxt        = ST_M;
    end else if (writeHit) begin
      cpu_nxt = ST_M;
      case (cpu_cur)
        ST_I:    write_miss_nxt = 1'b1;
        ST_S:    invalidate_nxt = 1'b1;
        default: ;
      endcase
    end else if (readMiss) begin
      read_miss_nxt  = 1'b1;
      write_back_nxt = (cpu_cur == ST_M);
      cpu_nxt        = fill_state;
    end else if (readHit) begin
      if (cpu_cur == ST_I) begin
        read_miss_nxt = 1'b1;
        cpu_nxt       = fill_state;
      end
    end
  end

  // Bus side: busWriteMiss > busInvalidate > busReadMiss
  always_comb begin
    bus_nxt   = bus_cur;
    abort_nxt = 1'b0;
    if (bus_cur != ST_I) begin
      if (busWriteMiss) begin
        bus_nxt   = ST_I;
        abort_nxt = (bus_cur == ST_M);
      end else if (busInvalidate) begin
        bus_nxt = ST_I;
      end else if (busReadMiss) begin
        bus_nxt   = ST_S;
        abort_nxt = (bus_cur == ST_M);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_q        <= ST_I;
      bus_q        <= ST_I;
      read_miss_q  <= 1'b0;
      write_miss_q <= 1'b0;
      invalidate_q <= 1'b0;
      write_back_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      cpu_q        <= cpu_nxt;
      bus_q        <= bus_nxt;
      read_miss_q  <= read_miss_nxt;
      write_miss_q <= write_miss_nxt;
      invalidate_q <= invalidate_nxt;
      write_back_q <= write_back_nxt;
      abort_q      <= abort_nxt;
    end
  end

  assign proximoEstadoCpu      = cpu_q;
  assign proximoEstadoBus      = bus_q;
  assign sendReadMiss          = read_miss_q;
  assign sendWriteMiss         = write_miss_q;
  assign sendInvalidate        = invalidate_q;
  assign sendWriteBack         = write_back_q;
  assign sendAbortMemoryAccess = abort_q;

endmodule

// File: tb/tb_maquina_mesi.sv
// Self-checking bench for maquina_mesi: scenario tasks push expected outputs to a
// scoreboard when inputs are driven and pop/compare them one cycle later.
module tb_maquina_mesi;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] estadoAnteriorCpu;
  logic       writeHit, readHit, writeMiss, readMiss, sharedIn;
  logic [2:0] proximoEstadoCpu;
  logic       sendReadMiss, sendWriteMiss, sendInvalidate, sendWriteBack;
  logic [2:0] estadoAnteriorBus;
  logic       busReadMiss, busWriteMiss, busInvalidate;
  logic       sendAbortMemoryAccess;
  logic [2:0] proximoEstadoBus;

  maquina_mesi dut (
    .clock                 (clock),
    .reset                 (reset),
    .estadoAnteriorCpu     (estadoAnteriorCpu),
    .writeHit              (writeHit),
    .readHit               (readHit),
    .writeMiss             (writeMiss),
    .readMiss              (readMiss),
    .sharedIn              (sharedIn),
    .proximoEstadoCpu      (proximoEstadoCpu),
    .sendReadMiss          (sendReadMiss),
    .sendWriteMiss         (sendWriteMiss),
    .sendInvalidate        (sendInvalidate),
    .sendWriteBack         (sendWriteBack),
    .estadoAnteriorBus     (estadoAnteriorBus),
    .busReadMiss           (busReadMiss),
    .busWriteMiss          (busWriteMiss),
    .busInvalidate         (busInvalidate),
    .sendAbortMemoryAccess (sendAbortMemoryAccess),
    .proximoEstadoBus      (proximoEstadoBus)
  );

  always #5 clock = ~clock;

  // {cpu_next[2:0], readMiss, writeMiss, invalidate, writeBack, bus_next[2:0], abort}
  logic [10:0] obs;
  assign obs = {proximoEstadoCpu, sendReadMiss, sendWriteMiss, sendInvalidate,
                sendWriteBack, proximoEstadoBus, sendAbortMemoryAccess};

  logic [10:0] sb[$];
  int total = 0;
  int bad   = 0;

  localparam logic [2:0] I = 3'b000, M = 3'b001, S = 3'b010, E = 3'b011;

  function automatic logic [10:0] pack(input logic [2:0] c, input logic rm, wm, inv, wb,
                                       input logic [2:0] b, input logic ab);
    pack = {c, rm, wm, inv, wb, b, ab};
  endfunction

  // Reference model written directly from the transition tables.
  function automatic logic [10:0] model(input logic [2:0] cs, input logic wh, rh, wm, rm, sh,
                                        input logic [2:0] bs, input logic brm, bwm, binv);
    logic [2:0] c, b, cn, bn, rf;
    logic r_rm, r_wm, r_inv, r_wb, r_ab;
    c = cs[2] ? I : cs;
    b = bs[2] ? I : bs;
    rf = sh ? S : E;
    {r_rm, r_wm, r_inv, r_wb, r_ab} = '0;
    cn = c;
    if (wm) begin
      cn = M; r_wm = 1'b1; r_wb = (c == M);
    end else if (wh) begin
      cn = M;
      if (c == I) r_wm = 1'b1;
      if (c == S) r_inv = 1'b1;
    end else if (rm) begin
      cn = rf; r_rm = 1'b1; r_wb = (c == M);
    end else if (rh && c == I) begin
      cn = rf; r_rm = 1'b1;
    end
    bn = b;
    if (b != I) begin
      if (bwm) begin
        bn = I; r_ab = (b == M);
      end else if (binv) begin
        bn = I;
      end else if (brm) begin
        bn = S; r_ab = (b == M);
      end
    end
    model = pack(cn, r_rm, r_wm, r_inv, r_wb, bn, r_ab);
  endfunction

  task automatic set_in(input logic [2:0] cs, input logic wh, rh, wm, rm, sh,
                        input logic [2:0] bs, input logic brm, bwm, binv);
    estadoAnteriorCpu = cs; writeHit = wh; readHit = rh; writeMiss = wm;
    readMiss = rm; sharedIn = sh; estadoAnteriorBus = bs;
    busReadMiss = brm; busWriteMiss = bwm; busInvalidate = binv;
  endtask

  task automatic drive(input logic [2:0] cs, input logic wh, rh, wm, rm, sh,
                       input logic [2:0] bs, input logic brm, bwm, binv,
                       input logic [10:0] expv);
    @(negedge clock);
    set_in(cs, wh, rh, wm, rm, sh, bs, brm, bwm, binv);
    sb.push_back(expv);
  endtask

  task automatic test_reset();
    logic [10:0] expv;
    reset = 1'b0;
    set_in(S, 0, 0, 0, 1, 0, M, 1, 0, 0);
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_initial: got %b want %b", obs, 11'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    sb.push_back(pack(E, 1, 0, 0, 0, S, 1));
    @(posedge clock); #1;
    expv = sb.pop_front();
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", obs, expv);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", obs, 11'd0);
    end
    @(negedge clock);
    set_in(S, 0, 0, 0, 1, 1, I, 0, 0, 0);
    reset = 1'b1;
    sb.push_back(pack(S, 1, 0, 0, 0, I, 0));
    @(posedge clock); #1;
    expv = sb.pop_front();
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL reset_release_shared: got %b want %b", obs, expv);
    end
  endtask

  task automatic test_cpu_read();
    logic [10:0] expv;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(I, 0, 0, 0, 1, 0, I, 0, 0, 0, pack(E, 1, 0, 0, 0, I, 0));
        1: drive(I, 0, 0, 0, 1, 1, I, 0, 0, 0, pack(S, 1, 0, 0, 0, I, 0));
        2: drive(I, 0, 1, 0, 0, 0, I, 0, 0, 0, pack(E, 1, 0, 0, 0, I, 0));
        3: drive(3'b101, 0, 0, 0, 1, 1, I, 0, 0, 0, pack(S, 1, 0, 0, 0, I, 0));
        default: drive(E, 0, 0, 0, 1, 1, I, 0, 0, 0, pack(S, 1, 0, 0, 0, I, 0));
      endcase
      @(posedge clock); #1;
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL cpu_read[%0d]: got %b want %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_cpu_write();
    logic [10:0] expv;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: drive(S, 1, 0, 0, 0, 0, I, 0, 0, 0, pack(M, 0, 0, 1, 0, I, 0));
        1: drive(E, 1, 0, 0, 0, 0, I, 0, 0, 0, pack(M, 0, 0, 0, 0, I, 0));
        2: drive(I, 1, 0, 0, 0, 0, I, 0, 0, 0, pack(M, 0, 1, 0, 0, I, 0));
        3: drive(M, 0, 0, 0, 1, 1, I, 0, 0, 0, pack(S, 1, 0, 0, 1, I, 0));
        4: drive(M, 0, 0, 1, 0, 0, I, 0, 0, 0, pack(M, 0, 1, 0, 1, I, 0));
        5: drive(M, 0, 1, 0, 0, 0, I, 0, 0, 0, pack(M, 0, 0, 0, 0, I, 0));
        6: drive(S, 0, 1, 0, 0, 1, I, 0, 0, 0, pack(S, 0, 0, 0, 0, I, 0));
        default: drive(E, 0, 0, 1, 0, 0, I, 0, 0, 0, pack(M, 0, 1, 0, 0, I, 0));
      endcase
      @(posedge clock); #1;
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL cpu_write[%0d]: got %b want %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_bus();
    logic [10:0] expv;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drive(I, 0, 0, 0, 0, 0, M, 1, 0, 0, pack(I, 0, 0, 0, 0, S, 1));
        1: drive(I, 0, 0, 0, 0, 0, M, 0, 1, 0, pack(I, 0, 0, 0, 0, I, 1));
        2: drive(I, 0, 0, 0, 0, 0, S, 0, 0, 1, pack(I, 0, 0, 0, 0, I, 0));
        3: drive(I, 0, 0, 0, 0, 0, E, 1, 0, 0, pack(I, 0, 0, 0, 0, S, 0));
        4: drive(I, 0, 0, 0, 0, 0, M, 0, 0, 1, pack(I, 0, 0, 0, 0, I, 0));
        5: drive(I, 0, 0, 0, 0, 0, I, 1, 1, 1, pack(I, 0, 0, 0, 0, I, 0));
        default: drive(I, 0, 0, 0, 0, 0, S, 1, 0, 0, pack(I, 0, 0, 0, 0, S, 0));
      endcase
      @(posedge clock); #1;
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL bus[%0d]: got %b want %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_priority();
    logic [10:0] expv;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(S, 0, 1, 1, 0, 0, I, 0, 0, 0, pack(M, 0, 1, 0, 0, I, 0));
        1: drive(I, 0, 0, 0, 0, 0, E, 1, 1, 0, pack(I, 0, 0, 0, 0, I, 0));
        2: drive(E, 0, 0, 0, 0, 0, E, 0, 0, 0, pack(E, 0, 0, 0, 0, E, 0));
        3: drive(M, 0, 0, 1, 0, 0, M, 1, 0, 0, pack(M, 0, 1, 0, 1, S, 1));
        default: drive(S, 1, 0, 0, 1, 0, M, 1, 0, 1, pack(M, 0, 0, 1, 0, I, 0));
      endcase
      @(posedge clock); #1;
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL priority[%0d]: got %b want %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] expv;
    logic [2:0]  cs, bs;
    logic [8:0]  ev;
    for (int k = 0; k < 200; k++) begin
      cs = 3'($urandom_range(0, 3));
      bs = 3'($urandom_range(0, 3));
      ev = 9'($urandom);
      drive(cs, ev[0], ev[1], ev[2], ev[3], ev[4], bs, ev[5], ev[6], ev[7],
            model(cs, ev[0], ev[1], ev[2], ev[3], ev[4], bs, ev[5], ev[6], ev[7]));
      @(posedge clock); #1;
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %b want %b", k, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_bus();
    test_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
